cmd_pkt_rx: RTL

Parametrised command-packet receiver for the quadcopter side of the remote link. Deserialises 8N1 UART bytes, assembles each packet as one command byte followed by DATA_BYTES data bytes, and buffers up to FIFO_DEPTH complete packets for the flight controller. It extends the fixed 3-byte command receiver with variable payload width, packet buffering, an inter-byte timeout, error reporting and an optional checksum.

---
 rtl/cmd_pkt_pkg.sv | 15 +
 rtl/uart_byte_rx.sv | 83 ++++++++
 rtl/cmd_pkt_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cmd_pkt_pkg.sv
// Shared types and constants for the command-packet receiver.
// Contents: pkt_state_t (packet FSM states), BAUD_DIV_19200, BYTE_W.
// Optional feature macro: CMD_PKT_CHKSUM_EN adds the PKT_CHK state.
package cmd_pkt_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BAUD_DIV_19200 = 2604;  // 19200 baud at 50 MHz

`ifdef CMD_PKT_CHKSUM_EN
    typedef enum logic [1:0] {PKT_IDLE, PKT_DATA, PKT_CHK} pkt_state_t;
`else
    typedef enum logic [1:0] {PKT_IDLE, PKT_DATA} pkt_state_t;
`endif

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, start-edge detect, mid-bit sampling, LSB first.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   rx       in   asynchronous serial input, idles high
//   byte_vld out  1-cycle strobe, rx_byte holds a good byte
//   rx_byte  out  last received byte
//   frm_err  out  1-cycle strobe, stop bit sampled as 0 (byte discarded)
module uart_byte_rx
    import cmd_pkt_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_19200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              byte_vld,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              frm_err
);

    localparam int unsigned   CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_CNT = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_DIV - 1);
    localparam logic [3:0]    STOP_BIT = 4'd9;  // bit 0 is start, 1..8 data

    logic              rx_meta, rx_sync, rx_prev;
    logic              busy_q;
    logic [CW-1:0]     baud_cnt_q;
    logic [3:0]        bit_cnt_q;
    logic [BYTE_W-1:0] shreg_q;
    logic              byte_vld_q, frm_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchroniser resets to the idle level so release does not fake a start edge.
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            busy_q     <= 1'b0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
            if (!busy_q) begin
                if (rx_prev && !rx_sync) begin
                    busy_q     <= 1'b1;
                    baud_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                end
            end else begin
                if (baud_cnt_q == LAST_CNT) begin
                    baud_cnt_q <= '0;
                    bit_cnt_q  <= bit_cnt_q + 4'd1;
                end else begin
                    baud_cnt_q <= baud_cnt_q + 1'b1;
                end
                if (baud_cnt_q == HALF_CNT) begin
                    if (bit_cnt_q == STOP_BIT) begin
                        // Back to idle at mid-stop so the next start edge is never missed.
                        busy_q     <= 1'b0;
                        byte_vld_q <= rx_sync;
                        frm_err_q  <= !rx_sync;
                    end else if (bit_cnt_q != 4'd0) begin
                        shreg_q <= {rx_sync, shreg_q[BYTE_W-1:1]};
                    end
                end
            end
        end
    end

    assign byte_vld = byte_vld_q;
    assign frm_err  = frm_err_q;
    assign rx_byte  = shreg_q;

endmodule

// File: rtl/cmd_pkt_rx.sv
// Command-packet receiver: UART bytes -> {cmd, DATA_BYTES data} packets -> FIFO_DEPTH packet FIFO.
// Optional feature macro: CMD_PKT_CHKSUM_EN (trailing mod-256 checksum byte, chk_err port).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   RX           serial input (8N1, idles high)
//   cmd, data    head packet (valid while cmd_rdy); first data byte is the MS byte of data
//   cmd_rdy      FIFO not empty
//   clr_cmd_rdy  pop head packet (ignored when empty)
//   fifo_cnt     number of buffered packets
//   frm_err, tmo_err, ovf (, chk_err)  1-cycle error pulses
module cmd_pkt_rx
    import cmd_pkt_pkg::*;
#(
    parameter int unsigned BAUD_DIV    = BAUD_DIV_19200,
    parameter int unsigned DATA_BYTES  = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 52080
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         RX,
    output logic [BYTE_W-1:0]            cmd,
    output logic [BYTE_W*DATA_BYTES-1:0] data,
    output logic                         cmd_rdy,
    input  logic                         clr_cmd_rdy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt,
    output logic                         frm_err,
    output logic                         tmo_err,
    output logic                         ovf
`ifdef CMD_PKT_CHKSUM_EN
    ,
    output logic                         chk_err
`endif
);

    localparam int unsigned DW = BYTE_W * DATA_BYTES;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic              byte_vld;
    logic [BYTE_W-1:0] rx_byte;

    uart_byte_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX),
        .byte_vld (byte_vld),
        .rx_byte  (rx_byte),
        .frm_err  (frm_err)
    );

    // Packet assembly FSM
    pkt_state_t        state_q, state_d;
    logic [BYTE_W-1:0] cmd_q, cmd_d;
    logic [DW-1:0]     data_q, data_d;
    logic [DW+7:0]     data_sh;
    logic [1:0]        idx_q, idx_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic              tmo_fire, tmo_err_q;
    logic              push;
`ifdef CMD_PKT_CHKSUM_EN
    logic [BYTE_W-1:0] sum_q, sum_d;
    logic              chk_fail, chk_err_q;
`endif

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        idx_d    = idx_q;
        push     = 1'b0;
        tmo_fire = 1'b0;
        data_sh  = {data_q, rx_byte};
`ifdef CMD_PKT_CHKSUM_EN
        sum_d    = sum_q;
        chk_fail = 1'b0;
`endif
        tmo_cnt_d = (state_q == PKT_IDLE || byte_vld) ? '0 : tmo_cnt_q + 1'b1;

        if (frm_err) begin
            state_d = PKT_IDLE;
        end else if (byte_vld) begin
            unique case (state_q)
                PKT_IDLE: begin
                    cmd_d   = rx_byte;
                    idx_d   = '0;
                    state_d = PKT_DATA;
`ifdef CMD_PKT_CHKSUM_EN
                    sum_d   = rx_byte;
`endif
                end
                PKT_DATA: begin
                    data_d = data_sh[DW-1:0];
                    idx_d  = idx_q + 2'd1;
`ifdef CMD_PKT_CHKSUM_EN
                    sum_d  = sum_q + rx_byte;
`endif
                    if (idx_q == 2'(DATA_BYTES - 1)) begin
`ifdef CMD_PKT_CHKSUM_EN
                        state_d = PKT_CHK;
`else
                        push    = 1'b1;
                        state_d = PKT_IDLE;
`endif
                    end
                end
`ifdef CMD_PKT_CHKSUM_EN
                PKT_CHK: begin
                    state_d = PKT_IDLE;
                    if (rx_byte == sum_q) begin
                        push = 1'b1;
                    end else begin
                        chk_fail = 1'b1;
                    end
                end
`endif
                default: state_d = PKT_IDLE;
            endcase
        end else if (state_q != PKT_IDLE && tmo_cnt_q == TW'(TIMEOUT_CYC)) begin
            tmo_fire  = 1'b1;
            tmo_cnt_d = '0;
            state_d   = PKT_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PKT_IDLE;
            cmd_q     <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
`ifdef CMD_PKT_CHKSUM_EN
            sum_q     <= '0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_fire;
`ifdef CMD_PKT_CHKSUM_EN
            sum_q     <= sum_d;
            chk_err_q <= chk_fail;
`endif
        end
    end

    // Packet FIFO
    logic [BYTE_W-1:0] st_cmd  [FIFO_DEPTH];
    logic [DW-1:0]     st_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       cnt_q;
    logic              full, empty, pop, wr_en, ovf_q;

    assign full  = (cnt_q == (PW + 1)'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign pop   = clr_cmd_rdy && !empty;
    // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                st_cmd[i]  <= '0;
                st_data[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= push && full && !pop;
            if (wr_en) begin
                st_cmd[wr_ptr_q]  <= cmd_q;
                st_data[wr_ptr_q] <= data_d;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!wr_en && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign cmd      = st_cmd[rd_ptr_q];
    assign data     = st_data[rd_ptr_q];
    assign cmd_rdy  = !empty;
    assign fifo_cnt = cnt_q;
    assign tmo_err  = tmo_err_q;
    assign ovf      = ovf_q;
`ifdef CMD_PKT_CHKSUM_EN
    assign chk_err  = chk_err_q;
`endif

endmodule
